// File: rtl/divisor_arbitro_pkg.sv
// Shared constants and tag-pipeline types for the shared-divider arbiter.
package divisor_pkg;
    localparam int unsigned TAMANYO_DEF = 32;
    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned LAT         = TAMANYO_DEF + 1;

    typedef logic [$clog2(N_REQ_DEF)-1:0] tag_t;

    typedef struct packed {
        logic                   valid;
        tag_t                   tag;
        logic                   dz;
        logic [TAMANYO_DEF-1:0] num;
    } etapa_t;
endpackage

// File: rtl/divisor_arbitro_if.sv
// Signal bundle between the clients, the pipelined divider and the arbiter.
interface divisor_arbitro_if #(
    parameter int unsigned tamanyo = divisor_pkg::TAMANYO_DEF,
    parameter int unsigned N_REQ   = divisor_pkg::N_REQ_DEF
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*tamanyo-1:0] req_num;
    logic [N_REQ*tamanyo-1:0] req_den;
    logic [N_REQ-1:0]         rsp_valid;
    logic [N_REQ-1:0]         rsp_ready;
    logic [N_REQ*tamanyo-1:0] rsp_coc;
    logic [N_REQ*tamanyo-1:0] rsp_res;
    logic [N_REQ-1:0]         rsp_dz;
    logic                     div_start;
    logic [tamanyo-1:0]       div_num;
    logic [tamanyo-1:0]       div_den;
    logic                     div_done;
    logic [tamanyo-1:0]       div_coc;
    logic [tamanyo-1:0]       div_res;
    logic                     err_sync;

    modport master (
        output req_valid, req_num, req_den, rsp_ready, div_done, div_coc, div_res,
        input  req_ready, rsp_valid, rsp_coc, rsp_res, rsp_dz,
               div_start, div_num, div_den, err_sync
    );

    modport slave (
        input  req_valid, req_num, req_den, rsp_ready, div_done, div_coc, div_res,
        output req_ready, rsp_valid, rsp_coc, rsp_res, rsp_dz,
               div_start, div_num, div_den, err_sync
    );
endinterface

// File: rtl/divisor_arbitro_rr.sv
// Round-robin grant: first eligible requester at or after ptr, cyclically.
module arbitro_rr #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned PW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    grant_idx,
    output logic             hay,
    output logic [PW-1:0]    ptr_sig
);
    logic [PW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        hay       = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = PW'((32'(ptr) + i) % N_REQ);
            if (!hay && elig[idx]) begin
                hay        = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
        ptr_sig = hay ? PW'((32'(grant_idx) + 1) % N_REQ) : ptr;
    end
endmodule

// File: rtl/divisor_arbitro.sv
// Shares one pipelined signed divider among N_REQ requesters: round-robin issue,
// tag pipeline aligned to the divider latency, per-requester response holding registers.
module divisor_arbitro #(
    parameter int unsigned tamanyo = divisor_pkg::TAMANYO_DEF,
    parameter int unsigned N_REQ   = divisor_pkg::N_REQ_DEF,
    parameter int unsigned LAT     = tamanyo + 1
) (
    input logic              CLK,
    input logic              RSTa,
    divisor_arbitro_if.slave bus
);
    localparam int unsigned PW = $clog2(N_REQ);

    typedef struct packed {
        logic               valid;
        logic [PW-1:0]      tag;
        logic               dz;
        logic [tamanyo-1:0] num;
    } etapa_l_t;

    etapa_l_t           etapa [LAT];
    etapa_l_t           entrada;
    etapa_l_t           cola;
    logic [N_REQ-1:0]   busy, elig, grant, rsp_valid_q, rsp_dz_q;
    logic [tamanyo-1:0] coc_q [N_REQ];
    logic [tamanyo-1:0] res_q [N_REQ];
    logic [PW-1:0]      ptr, ptr_sig, g_idx;
    logic [tamanyo-1:0] num_g, den_g;
    logic               hay, err_q, llega, fallo;

    // Gated by RSTa so req_ready/div_start also read 0 while reset is held.
    assign elig = bus.req_valid & ~busy & {N_REQ{RSTa}};

    arbitro_rr #(.N_REQ(N_REQ)) u_rr (
        .elig      (elig),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (g_idx),
        .hay       (hay),
        .ptr_sig   (ptr_sig)
    );

    always_comb begin
        num_g         = bus.req_num[32'(g_idx)*tamanyo +: tamanyo];
        den_g         = bus.req_den[32'(g_idx)*tamanyo +: tamanyo];
        entrada.valid = hay;
        entrada.tag   = g_idx;
        entrada.dz    = (den_g == '0);
        entrada.num   = num_g;
    end

    assign bus.req_ready = grant;
    assign bus.div_start = hay;
    assign bus.div_num   = hay ? num_g : '0;
    assign bus.div_den   = hay ? den_g : '0;

    assign cola  = etapa[LAT-1];
    assign llega = cola.valid & bus.div_done;
    assign fallo = cola.valid ^ bus.div_done;

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            for (int unsigned i = 0; i < LAT; i++) etapa[i] <= '0;
        end else begin
            etapa[0] <= entrada;
            for (int unsigned i = 1; i < LAT; i++) etapa[i] <= etapa[i-1];
        end
    end

    // Issue, consume and tail events never target the same requester in one cycle.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            busy        <= '0;
            rsp_valid_q <= '0;
            rsp_dz_q    <= '0;
            ptr         <= '0;
            err_q       <= 1'b0;
            for (int unsigned k = 0; k < N_REQ; k++) begin
                coc_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            ptr <= ptr_sig;
            if (fallo) err_q <= 1'b1;
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (grant[k]) busy[k] <= 1'b1;
                if (rsp_valid_q[k] && bus.rsp_ready[k]) begin
                    rsp_valid_q[k] <= 1'b0;
                    busy[k]        <= 1'b0;
                end
                if (cola.tag == PW'(k)) begin
                    if (fallo && cola.valid) busy[k] <= 1'b0;
                    if (llega) begin
                        rsp_valid_q[k] <= 1'b1;
                        rsp_dz_q[k]    <= cola.dz;
                        coc_q[k]       <= cola.dz ? '1 : bus.div_coc;
                        res_q[k]       <= cola.dz ? cola.num : bus.div_res;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < N_REQ; k++) begin : g_rsp
        assign bus.rsp_coc[k*tamanyo +: tamanyo] = coc_q[k];
        assign bus.rsp_res[k*tamanyo +: tamanyo] = res_q[k];
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dz    = rsp_dz_q;
    assign bus.err_sync  = err_q;
endmodule

// File: tb/tb_divisor_arbitro.sv
// Bench for divisor_arbitro: directed vector table, hand sequences and a random
// phase checked every cycle against a transaction-level model.
module tb_divisor_arbitro;
    import divisor_pkg::*;

    localparam int unsigned W = TAMANYO_DEF;
    localparam int unsigned N = N_REQ_DEF;
    localparam int unsigned L = LAT;

    logic CLK, RSTa, spur;
    int   tests, fails, cyc;
    bit   mon_en;

    divisor_arbitro_if #(.tamanyo(W), .N_REQ(N)) bus ();

    divisor_arbitro #(.tamanyo(W), .N_REQ(N), .LAT(L)) dut (
        .CLK  (CLK),
        .RSTa (RSTa),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural pipelined divider, L cycles from start to done.
    logic [L-1:0]        dv;
    logic [W-1:0]        dq [L];
    logic [W-1:0]        dr [L];
    logic signed [W-1:0] dn, dd, q_c, r_c;
    assign dn = bus.div_num;
    assign dd = bus.div_den;
    always_comb begin
        q_c = '0;
        r_c = '0;
        if (dd == '1) q_c = -dn;
        else if (dd != '0) begin
            q_c = dn / dd;
            r_c = dn % dd;
        end
    end
    always @(posedge CLK or negedge RSTa) begin
        if (!RSTa) dv <= '0;
        else begin
            dv    <= {dv[L-2:0], bus.div_start};
            dq[0] <= q_c;
            dr[0] <= r_c;
            for (int i = 1; i < L; i++) begin
                dq[i] <= dq[i-1];
                dr[i] <= dr[i-1];
            end
        end
    end
    assign bus.div_done = dv[L-1] | spur;
    assign bus.div_coc  = dq[L-1];
    assign bus.div_res  = dr[L-1];

    // Transaction-level model state.
    logic [N-1:0] busy_m;
    int           ptr_m;
    int           issue_c [N];
    logic [W-1:0] ecoc [N];
    logic [W-1:0] eres [N];
    logic         edz  [N];

    task automatic chk(input string nombre, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nombre, cyc, act, exp);
        end
    endtask

    function automatic logic [2*W:0] ref_div(input logic signed [W-1:0] n, input logic signed [W-1:0] d);
        logic signed [W-1:0] q, r;
        if (d == 0) return {{W{1'b1}}, n, 1'b1};
        q = n / d;
        r = n % d;
        return {q, r, 1'b0};
    endfunction

    task automatic modelo();
        logic [N-1:0]   exp_ready, ev;
        logic [2*W-1:0] exp_ops;
        logic [2*W:0]   t;
        int             g;
        if (!RSTa) begin
            busy_m = '0;
            ptr_m  = 0;
            return;
        end
        g = -1;
        for (int i = 0; i < int'(N); i++)
            if (g < 0 && bus.req_valid[(ptr_m + i) % N] && !busy_m[(ptr_m + i) % N])
                g = (ptr_m + i) % N;
        exp_ready = '0;
        exp_ops   = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            exp_ops      = {bus.req_num[g*W +: W], bus.req_den[g*W +: W]};
        end
        for (int k = 0; k < int'(N); k++)
            ev[k] = busy_m[k] && (cyc >= issue_c[k] + int'(L) + 1);
        if (mon_en) begin
            chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("div_start", 64'(bus.div_start), 64'(g >= 0));
            chk("div_ops", {bus.div_num, bus.div_den}, exp_ops);
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
            chk("err_sync", 64'(bus.err_sync), 64'(0));
            for (int k = 0; k < int'(N); k++)
                if (ev[k]) begin
                    chk("rsp_data", {bus.rsp_coc[k*W +: W], bus.rsp_res[k*W +: W]}, {ecoc[k], eres[k]});
                    chk("rsp_dz", 64'(bus.rsp_dz[k]), 64'(edz[k]));
                end
        end
        for (int k = 0; k < int'(N); k++)
            if (ev[k] && bus.rsp_ready[k]) busy_m[k] = 1'b0;
        if (g >= 0) begin
            busy_m[g]  = 1'b1;
            issue_c[g] = cyc;
            t          = ref_div(bus.req_num[g*W +: W], bus.req_den[g*W +: W]);
            ecoc[g]    = t[2*W:W+1];
            eres[g]    = t[W:1];
            edz[g]     = t[0];
            ptr_m      = (g + 1) % N;
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        modelo();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    function automatic logic [W-1:0] rnd_num();
        return W'(int'($urandom_range(2000000)) - 1000000);
    endfunction

    function automatic logic [W-1:0] rnd_den();
        if ($urandom_range(7) == 0) return '0;
        return W'(int'($urandom_range(2000)) - 1000);
    endfunction

    task automatic rnd_ops();
        for (int k = 0; k < int'(N); k++) begin
            bus.req_num[k*W +: W] = rnd_num();
            bus.req_den[k*W +: W] = rnd_den();
        end
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        RSTa = 1'b0;
        tick();
        tick();
        RSTa = 1'b1;
        tick();
    endtask

    typedef struct {
        int           k;
        logic [W-1:0] num, den, coc, res;
        logic         dz;
    } vec_t;

    vec_t         tabla [7];
    int           n, seen, others, k;
    logic [63:0]  hold;

    initial begin
        tabla[0] = '{0,  100,   7, 32'd14,         32'd2,          1'b0};
        tabla[1] = '{2, -100,   7, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
        tabla[2] = '{3,  100,  -7, 32'hFFFFFFF2,   32'd2,          1'b0};
        tabla[3] = '{1,   55,   0, 32'hFFFFFFFF,   32'd55,         1'b1};
        tabla[4] = '{1,   -9,  -2, 32'd4,          32'hFFFFFFFF,   1'b0};
        tabla[5] = '{0,    0,   5, 32'd0,          32'd0,          1'b0};
        tabla[6] = '{2,  -17,   0, 32'hFFFFFFFF,   32'hFFFFFFEF,   1'b1};

        tests = 0; fails = 0; cyc = 0; mon_en = 1'b0; spur = 1'b0; RSTa = 1'b0;
        bus.req_valid = '0; bus.req_num = '0; bus.req_den = '0; bus.rsp_ready = '0;
        tick();
        tick();
        chk("reset_ctrl", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_dz, bus.div_start, bus.err_sync}), 64'(0));
        chk("reset_data", 64'(|{bus.rsp_coc, bus.rsp_res, bus.div_num, bus.div_den}), 64'(0));
        bus.req_valid = '1;
        #1;
        chk("reset_no_ready", 64'(bus.req_ready), 64'(0));
        bus.req_valid = '0;
        RSTa   = 1'b1;
        mon_en = 1'b1;
        tick();

        for (int t = 0; t < 7; t++) begin
            k = tabla[t].k;
            bus.req_num[k*W +: W] = tabla[t].num;
            bus.req_den[k*W +: W] = tabla[t].den;
            bus.req_valid[k] = 1'b1;
            #1;
            chk("tv_ready", 64'(bus.req_ready), 64'(1) << k);
            n = 0;
            do begin
                tick();
                if (n == 0) bus.req_valid[k] = 1'b0;
                n++;
            end while (!bus.rsp_valid[k] && n < 100);
            chk("tv_latency", 64'(n), 64'(L + 1));
            chk("tv_coc", 64'(bus.rsp_coc[k*W +: W]), 64'(tabla[t].coc));
            chk("tv_res", 64'(bus.rsp_res[k*W +: W]), 64'(tabla[t].res));
            chk("tv_dz", 64'(bus.rsp_dz[k]), 64'(tabla[t].dz));
            bus.rsp_ready[k] = 1'b1;
            tick();
            bus.rsp_ready[k] = 1'b0;
            chk("tv_consumed", 64'(bus.rsp_valid[k]), 64'(0));
        end

        // Fairness from a fresh pointer.
        do_reset();
        bus.rsp_ready = '1;
        bus.req_valid = '1;
        for (int i = 0; i < int'(N); i++) begin
            rnd_ops();
            #1;
            chk("fair_grant", 64'(bus.req_ready), 64'(1) << i);
            tick();
        end
        n = 0;
        while (!bus.rsp_valid[0] && n < 100) begin
            tick();
            n++;
        end
        chk("fair_rsp0_seen", 64'(bus.rsp_valid[0]), 64'(1));
        chk("reissue_same_cycle", 64'(bus.req_ready[0]), 64'(0));
        tick();
        chk("reissue_next_cycle", 64'(bus.req_ready[0]), 64'(1));

        // Backpressure on requester 1.
        bus.rsp_ready[1] = 1'b0;
        n = 0;
        while (!bus.rsp_valid[1] && n < 100) begin
            tick();
            n++;
        end
        chk("bp_rsp1_seen", 64'(bus.rsp_valid[1]), 64'(1));
        hold   = {bus.rsp_coc[W +: W], bus.rsp_res[W +: W]};
        others = 0;
        for (int i = 0; i < 50; i++) begin
            chk("bp_no_grant", 64'(bus.req_ready[1]), 64'(0));
            chk("bp_hold", {bus.rsp_coc[W +: W], bus.rsp_res[W +: W]}, hold);
            if ((bus.req_ready & 4'b1101) != 0) others++;
            tick();
        end
        chk("bp_others_ran", 64'(others > 0), 64'(1));
        bus.rsp_ready[1] = 1'b1;
        n = 0;
        while (!bus.req_ready[1] && n < 100) begin
            tick();
            n++;
        end
        chk("bp_regrant", 64'(bus.req_ready[1]), 64'(1));

        for (int c = 0; c < 3000; c++) begin
            bus.req_valid = 4'($urandom);
            bus.rsp_ready = 4'($urandom);
            rnd_ops();
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        for (int c = 0; c < int'(L) + 5; c++) tick();

        // Reset with three operations in flight.
        bus.req_valid = 4'b0111;
        rnd_ops();
        for (int c = 0; c < 3; c++) tick();
        bus.req_valid = '0;
        for (int c = 0; c < 10; c++) tick();
        #1;
        RSTa = 1'b0;
        #1;
        chk("midrst_ctrl", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_dz, bus.div_start, bus.err_sync}), 64'(0));
        chk("midrst_data", 64'(|{bus.rsp_coc, bus.rsp_res, bus.div_num, bus.div_den}), 64'(0));
        tick();
        tick();
        RSTa = 1'b1;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bus.rsp_valid != '0) seen++;
        end
        chk("midrst_no_rsp", 64'(seen), 64'(0));
        chk("midrst_no_err", 64'(bus.err_sync), 64'(0));
        mon_en = 1'b0;
        spur   = 1'b1;
        tick();
        spur = 1'b0;
        chk("spurious_err", 64'(bus.err_sync), 64'(1));
        for (int c = 0; c < 3; c++) tick();
        chk("err_sticky", 64'(bus.err_sync), 64'(1));
        chk("spurious_no_rsp", 64'(bus.rsp_valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
